cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, per-source holding-buffer depth in entries (power of two, >=2).
REQ-002 Parameter NSRC, fixed 3, number of requesters: 0=ALU, 1=load unit, 2=address unit.
REQ-003 clk_in  input  1  single clock; all state updates on posedge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 rdy_in  input  1  global enable; when low all state and outputs hold.
REQ-006 rob_cdb_rst_in  input  1  misprediction flush from reorder buffer.
REQ-007 alu_cdb_en_in / lsu_cdb_en_in / addr_cdb_en_in  input  1 each  result-valid strobe per source.
REQ-008 alu_cdb_b_in / lsu_cdb_b_in / addr_cdb_b_in  input  ROBWidth each  destination ROB tag; 0 = no ROB entry.
REQ-009 alu_cdb_result_in / lsu_cdb_result_in / addr_cdb_result_in  input  IDWidth each  result value.
REQ-010 cdb_alu_rdy_out / cdb_lsu_rdy_out / cdb_addr_rdy_out  output  1 each  source buffer has a free entry.
REQ-011 cdb_en_out  output  1  broadcast valid this cycle.
REQ-012 cdb_b_out  output  ROBWidth  broadcast ROB tag.
REQ-013 cdb_result_out  output  IDWidth  broadcast value.

Function
REQ-014 Each source SHALL own a FIFO of FIFO_DEPTH entries {tag, value} with head/tail pointers wrapping modulo FIFO_DEPTH and an occupancy count.
REQ-015 A push SHALL occur at a rising edge when rdy_in=1, en_in=1, b_in!=0 and the source's rdy_out=1; a strobe with b_in=0 SHALL be dropped.
REQ-016 rdy_out SHALL be combinational from registered occupancy only: high iff count<FIFO_DEPTH; a strobe while rdy_out=0 SHALL be dropped and not corrupt state.
REQ-017 At most one entry SHALL be popped per cycle, chosen round-robin among non-empty FIFOs starting at priority pointer ptr (2-bit, values 0..2).
REQ-018 After a grant to source g, ptr SHALL become (g+1) mod 3; with no grant ptr SHALL hold.
REQ-019 The popped entry SHALL drive registered outputs: cdb_en_out=1, cdb_b_out/cdb_result_out=entry at the following edge; with no grant cdb_en_out=0 and tag/value hold their previous values.
REQ-020 Latency: a push at edge N into an empty FIFO that wins arbitration SHALL be broadcast (cdb_en_out=1) during the cycle after edge N+1; no same-cycle bypass.
REQ-021 Push and pop of the same FIFO in one cycle SHALL both take effect; count unchanged.
REQ-022 Simultaneous pushes from all three sources SHALL all be accepted when their rdy_out=1.
REQ-023 rob_cdb_rst_in=1 (with rdy_in=1) SHALL empty all FIFOs, set ptr=0, force cdb_en_out=0 at that edge, and discard same-cycle pushes.
REQ-024 rdy_in=0 SHALL freeze FIFOs, ptr and all outputs, ignoring strobes and flush.

Reset
REQ-025 rst_in=1 at an edge SHALL clear all counts and pointers, set ptr=0, cdb_en_out=0, cdb_b_out=0, cdb_result_out=0, regardless of rdy_in.
REQ-026 Reset mid-operation SHALL discard all buffered results; rdy_out of every source reads 1 in the cycle after reset.

Structure
REQ-027 ROBWidth, IDWidth and the null-tag value SHALL come from the shared constant.vh; no local redefinition.
REQ-028 One sub-module, cdb_src_fifo (depth-parameterised tag/value FIFO with push, pop, flush, count), SHALL be instantiated three times; arbitration and output registers stay in cdb_arbiter.

Verification
REQ-029 ALU pushes tag 3/value 0x11 at edge 1 -> cdb_en_out=1, b=3, result=0x11 after edge 2; cdb_en_out=0 after edge 3.
REQ-030 All three push at edge 1 (tags 1,2,3), ptr=0 -> broadcasts tag 1, 2, 3 after edges 2, 3, 4; ptr returns to 0.
REQ-031 ALU pushes 3 results back-to-back with no pops possible (LSU/addr continuously granted scenario, depth 2) -> cdb_alu_rdy_out=0 when count=2, third strobe dropped, only two ALU tags broadcast.
REQ-032 Strobe with b_in=0 on LSU -> no broadcast, LSU count stays 0.
REQ-033 Two entries buffered, rob_cdb_rst_in=1 with concurrent addr push tag 5 -> cdb_en_out=0 next cycle, no tag 5 ever broadcast, all rdy_out=1.
REQ-034 rdy_in=0 for 3 cycles with pending ALU tag 4 -> outputs frozen; tag 4 broadcast one cycle after rdy_in returns high.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common-data-bus arbiter slice.
// This package is the single home of the ROB tag width, result width and
// null tag; other files import it rather than redefining them.
package cdb_arbiter_pkg;

  localparam int ROBWidth = 4;
  localparam int IDWidth  = 32;
  localparam logic [ROBWidth-1:0] NullTag = '0;

  // Number of result producers competing for the bus.
  localparam int NSRC = 3;

  // Source identifiers double as round-robin priority pointer values.
  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_LSU  = 2'd1,
    SRC_ADDR = 2'd2
  } src_e;

  // One buffered result waiting for the bus.
  typedef struct packed {
    logic [ROBWidth-1:0] tag;
    logic [IDWidth-1:0]  value;
  } cdb_entry_t;

  // Adds an offset to a source index, wrapping modulo NSRC.
  function automatic src_e wrap3(input src_e base, input logic [1:0] off);
    logic [2:0] sum;
    logic [2:0] wrapped;
    sum     = {1'b0, base} + {1'b0, off};
    wrapped = (sum >= 3'd3) ? (sum - 3'd3) : sum;
    return src_e'(wrapped[1:0]);
  endfunction

  // Priority pointer value after a grant to source g.
  function automatic src_e next_ptr(input src_e g);
    return wrap3(g, 2'd1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bus bundle between the three result producers and the CDB arbiter.
// The master side is the producers/consumers of the bus; the slave side is
// the arbiter itself.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic                alu_cdb_en_in;
  logic [ROBWidth-1:0] alu_cdb_b_in;
  logic [IDWidth-1:0]  alu_cdb_result_in;
  logic                lsu_cdb_en_in;
  logic [ROBWidth-1:0] lsu_cdb_b_in;
  logic [IDWidth-1:0]  lsu_cdb_result_in;
  logic                addr_cdb_en_in;
  logic [ROBWidth-1:0] addr_cdb_b_in;
  logic [IDWidth-1:0]  addr_cdb_result_in;

  logic                cdb_alu_rdy_out;
  logic                cdb_lsu_rdy_out;
  logic                cdb_addr_rdy_out;

  logic                cdb_en_out;
  logic [ROBWidth-1:0] cdb_b_out;
  logic [IDWidth-1:0]  cdb_result_out;

  modport master (
    output alu_cdb_en_in, alu_cdb_b_in, alu_cdb_result_in,
    output lsu_cdb_en_in, lsu_cdb_b_in, lsu_cdb_result_in,
    output addr_cdb_en_in, addr_cdb_b_in, addr_cdb_result_in,
    input  cdb_alu_rdy_out, cdb_lsu_rdy_out, cdb_addr_rdy_out,
    input  cdb_en_out, cdb_b_out, cdb_result_out
  );

  modport slave (
    input  alu_cdb_en_in, alu_cdb_b_in, alu_cdb_result_in,
    input  lsu_cdb_en_in, lsu_cdb_b_in, lsu_cdb_result_in,
    input  addr_cdb_en_in, addr_cdb_b_in, addr_cdb_result_in,
    output cdb_alu_rdy_out, cdb_lsu_rdy_out, cdb_addr_rdy_out,
    output cdb_en_out, cdb_b_out, cdb_result_out
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source holding buffer of {tag, value} results awaiting the bus.
// Pointers wrap naturally because the depth is a power of two. Callers are
// expected to gate push with "not full" and pop with "not empty".
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          flush_in,
  input  logic                          push_in,
  input  cdb_entry_t                    push_entry,
  input  logic                          pop_in,
  output cdb_entry_t                    head_entry,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  cdb_entry_t    mem [FIFO_DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  // Storage array: written at the tail on every accepted push, no reset needed.
  always_ff @(posedge clk_in) begin
    if (push_in) begin
      mem[tail_ptr] <= push_entry;
    end
  end

  // Pointers and occupancy; reset and flush both empty the buffer.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push_in) begin
        tail_ptr <= tail_ptr + PW'(1);
      end
      if (pop_in) begin
        head_ptr <= head_ptr + PW'(1);
      end
      case ({push_in, pop_in})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_entry = mem[head_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers results from the ALU, load unit and
// address unit, then broadcasts at most one per cycle in round-robin order.
// The broadcast is registered, so a result always spends at least one full
// cycle in its buffer before appearing on the bus.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_cdb_rst_in,
  cdb_arbiter_if.slave      bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NSRC-1:0] src_en;
  cdb_entry_t      src_entry  [NSRC];
  cdb_entry_t      head_entry [NSRC];
  logic [CW-1:0]   fifo_count [NSRC];
  logic [NSRC-1:0] src_rdy;
  logic [NSRC-1:0] src_push;
  logic [NSRC-1:0] src_pop;
  logic            flush;

  src_e            ptr;
  src_e            grant_src;
  src_e            idx;
  logic            grant_valid;
  cdb_entry_t      grant_entry;

  logic                cdb_en_q;
  logic [ROBWidth-1:0] cdb_b_q;
  logic [IDWidth-1:0]  cdb_result_q;

  assign src_en = {bus.addr_cdb_en_in, bus.lsu_cdb_en_in, bus.alu_cdb_en_in};
  assign src_entry[SRC_ALU]  = {bus.alu_cdb_b_in,  bus.alu_cdb_result_in};
  assign src_entry[SRC_LSU]  = {bus.lsu_cdb_b_in,  bus.lsu_cdb_result_in};
  assign src_entry[SRC_ADDR] = {bus.addr_cdb_b_in, bus.addr_cdb_result_in};

  // A flush only counts when the pipeline is enabled.
  assign flush = rdy_in & rob_cdb_rst_in;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    assign src_rdy[s]  = (fifo_count[s] < CW'(FIFO_DEPTH));
    assign src_push[s] = rdy_in & ~rob_cdb_rst_in & src_en[s] &
                         (src_entry[s].tag != NullTag) & src_rdy[s];
    assign src_pop[s]  = rdy_in & ~rob_cdb_rst_in & grant_valid &
                         (grant_src == src_e'(s));

    cdb_src_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .flush_in   (flush),
      .push_in    (src_push[s]),
      .push_entry (src_entry[s]),
      .pop_in     (src_pop[s]),
      .head_entry (head_entry[s]),
      .count      (fifo_count[s])
    );
  end

  assign bus.cdb_alu_rdy_out  = src_rdy[SRC_ALU];
  assign bus.cdb_lsu_rdy_out  = src_rdy[SRC_LSU];
  assign bus.cdb_addr_rdy_out = src_rdy[SRC_ADDR];

  // Round-robin pick: first non-empty buffer scanning upward from ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = ptr;
    grant_entry = head_entry[ptr];
    idx         = ptr;
    for (int k = 0; k < NSRC; k++) begin
      idx = wrap3(ptr, 2'(k));
      if (!grant_valid && (fifo_count[idx] != '0)) begin
        grant_valid = 1'b1;
        grant_src   = idx;
        grant_entry = head_entry[idx];
      end
    end
  end

  // Broadcast registers and priority pointer; everything holds when rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_en_q     <= 1'b0;
      cdb_b_q      <= '0;
      cdb_result_q <= '0;
      ptr          <= SRC_ALU;
    end else if (rdy_in) begin
      if (rob_cdb_rst_in) begin
        cdb_en_q <= 1'b0;
        ptr      <= SRC_ALU;
      end else if (grant_valid) begin
        cdb_en_q     <= 1'b1;
        cdb_b_q      <= grant_entry.tag;
        cdb_result_q <= grant_entry.value;
        ptr          <= next_ptr(grant_src);
      end else begin
        cdb_en_q <= 1'b0;
      end
    end
  end

  assign bus.cdb_en_out     = cdb_en_q;
  assign bus.cdb_b_out      = cdb_b_q;
  assign bus.cdb_result_out = cdb_result_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin order, back-pressure,
// null-tag drop, flush, global stall and reset behaviour.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk_in;
  logic rst_in;
  logic rdy_in;
  logic rob_cdb_rst_in;

  int n_compared   = 0;
  int n_mismatched = 0;

  cdb_arbiter_if bus ();

  cdb_arbiter #(
    .FIFO_DEPTH (2)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .rob_cdb_rst_in (rob_cdb_rst_in),
    .bus            (bus)
  );

  // 10-unit clock.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] observed,
                              input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", name, observed, expected);
    end
  endtask

  task automatic check_cdb(input string name, input logic en,
                           input logic [ROBWidth-1:0] tag, input logic [IDWidth-1:0] value);
    check_output({name, ".en"},     64'(bus.cdb_en_out),     64'(en));
    check_output({name, ".b"},      64'(bus.cdb_b_out),      64'(tag));
    check_output({name, ".result"}, 64'(bus.cdb_result_out), 64'(value));
  endtask

  task automatic check_rdy(input string name, input logic alu, input logic lsu, input logic addr);
    check_output({name, ".rdy"},
                 64'({bus.cdb_alu_rdy_out, bus.cdb_lsu_rdy_out, bus.cdb_addr_rdy_out}),
                 64'({alu, lsu, addr}));
  endtask

  // en bits: [0]=ALU, [1]=LSU, [2]=address unit.
  task automatic apply_stimulus(input logic [2:0] en,
                                input logic [ROBWidth-1:0] t0, input logic [IDWidth-1:0] v0,
                                input logic [ROBWidth-1:0] t1, input logic [IDWidth-1:0] v1,
                                input logic [ROBWidth-1:0] t2, input logic [IDWidth-1:0] v2);
    bus.alu_cdb_en_in      = en[0];
    bus.alu_cdb_b_in       = t0;
    bus.alu_cdb_result_in  = v0;
    bus.lsu_cdb_en_in      = en[1];
    bus.lsu_cdb_b_in       = t1;
    bus.lsu_cdb_result_in  = v1;
    bus.addr_cdb_en_in     = en[2];
    bus.addr_cdb_b_in      = t2;
    bus.addr_cdb_result_in = v2;
  endtask

  task automatic idle();
    apply_stimulus(3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in         = 1'b1;
    rdy_in         = 1'b0;
    rob_cdb_rst_in = 1'b0;
    idle();

    // Reset clears outputs even with rdy_in low.
    step();
    step();
    check_cdb("reset", 1'b0, 4'd0, 32'h0);
    check_rdy("reset", 1'b1, 1'b1, 1'b1);
    rst_in = 1'b0;
    rdy_in = 1'b1;

    // Single ALU result: two-edge latency, then idle.
    apply_stimulus(3'b001, 4'd3, 32'h11, 0, 0, 0, 0);
    step();
    idle();
    check_cdb("single.nobypass", 1'b0, 4'd0, 32'h0);
    step();
    check_cdb("single.bcast", 1'b1, 4'd3, 32'h11);
    step();
    check_cdb("single.after", 1'b0, 4'd3, 32'h11);

    // Back-pressure: ptr=1, ALU fills to depth 2 and a third strobe is dropped.
    apply_stimulus(3'b111, 4'd1, 32'hA1, 4'd2, 32'hB2, 4'd4, 32'hC4);
    step();
    check_cdb("bp.e1", 1'b0, 4'd3, 32'h11);
    check_rdy("bp.e1", 1'b1, 1'b1, 1'b1);
    apply_stimulus(3'b001, 4'd5, 32'hA5, 0, 0, 0, 0);
    step();
    check_cdb("bp.lsu", 1'b1, 4'd2, 32'hB2);
    check_rdy("bp.full", 1'b0, 1'b1, 1'b1);
    apply_stimulus(3'b001, 4'd6, 32'hA6, 0, 0, 0, 0);
    step();
    check_cdb("bp.addr", 1'b1, 4'd4, 32'hC4);
    check_rdy("bp.drop", 1'b0, 1'b1, 1'b1);
    idle();
    step();
    check_cdb("bp.alu1", 1'b1, 4'd1, 32'hA1);
    check_rdy("bp.drain", 1'b1, 1'b1, 1'b1);
    step();
    check_cdb("bp.alu2", 1'b1, 4'd5, 32'hA5);
    step();
    check_cdb("bp.empty", 1'b0, 4'd5, 32'hA5);
    step();
    check_cdb("bp.no_tag6", 1'b0, 4'd5, 32'hA5);

    // Reset mid-operation discards buffered results.
    apply_stimulus(3'b011, 4'd7, 32'h77, 4'd8, 32'h88, 0, 0);
    step();
    check_cdb("midrst.push", 1'b0, 4'd5, 32'hA5);
    idle();
    rst_in = 1'b1;
    step();
    check_cdb("midrst.reset", 1'b0, 4'd0, 32'h0);
    check_rdy("midrst.reset", 1'b1, 1'b1, 1'b1);
    rst_in = 1'b0;
    step();
    check_cdb("midrst.discard", 1'b0, 4'd0, 32'h0);

    // All three push together from ptr=0: broadcast in order 1,2,3.
    apply_stimulus(3'b111, 4'd1, 32'h21, 4'd2, 32'h22, 4'd3, 32'h23);
    step();
    idle();
    check_cdb("rr.e1", 1'b0, 4'd0, 32'h0);
    step();
    check_cdb("rr.alu", 1'b1, 4'd1, 32'h21);
    step();
    check_cdb("rr.lsu", 1'b1, 4'd2, 32'h22);
    step();
    check_cdb("rr.addr", 1'b1, 4'd3, 32'h23);
    step();
    check_cdb("rr.done", 1'b0, 4'd3, 32'h23);

    // ptr back at 0 means LSU beats the address unit.
    apply_stimulus(3'b110, 0, 0, 4'd9, 32'h99, 4'd10, 32'hAA);
    step();
    idle();
    check_cdb("rrptr.e1", 1'b0, 4'd3, 32'h23);
    step();
    check_cdb("rrptr.lsu", 1'b1, 4'd9, 32'h99);
    step();
    check_cdb("rrptr.addr", 1'b1, 4'd10, 32'hAA);
    step();
    check_cdb("rrptr.done", 1'b0, 4'd10, 32'hAA);

    // Null tag on LSU is dropped.
    apply_stimulus(3'b010, 0, 0, 4'd0, 32'h55, 0, 0);
    step();
    idle();
    check_cdb("null.e1", 1'b0, 4'd10, 32'hAA);
    check_rdy("null.e1", 1'b1, 1'b1, 1'b1);
    step();
    check_cdb("null.e2", 1'b0, 4'd10, 32'hAA);

    // Flush with two entries buffered and a concurrent address push.
    apply_stimulus(3'b111, 4'd1, 32'h31, 4'd2, 32'h32, 4'd3, 32'h33);
    step();
    idle();
    check_cdb("flush.fill", 1'b0, 4'd10, 32'hAA);
    step();
    check_cdb("flush.alu", 1'b1, 4'd1, 32'h31);
    apply_stimulus(3'b100, 0, 0, 0, 0, 4'd5, 32'h35);
    rob_cdb_rst_in = 1'b1;
    step();
    check_cdb("flush.edge", 1'b0, 4'd1, 32'h31);
    check_rdy("flush.edge", 1'b1, 1'b1, 1'b1);
    rob_cdb_rst_in = 1'b0;
    apply_stimulus(3'b101, 4'd6, 32'h36, 0, 0, 4'd7, 32'h37);
    step();
    idle();
    check_cdb("flush.nodrain", 1'b0, 4'd1, 32'h31);
    step();
    check_cdb("flush.ptr0", 1'b1, 4'd6, 32'h36);
    step();
    check_cdb("flush.addr", 1'b1, 4'd7, 32'h37);
    step();
    check_cdb("flush.done", 1'b0, 4'd7, 32'h37);

    // Global stall: pending ALU tag 4, strobes and flush ignored while frozen.
    apply_stimulus(3'b001, 4'd4, 32'h44, 0, 0, 0, 0);
    step();
    check_cdb("stall.push", 1'b0, 4'd7, 32'h37);
    rdy_in = 1'b0;
    rob_cdb_rst_in = 1'b1;
    apply_stimulus(3'b010, 0, 0, 4'd9, 32'h99, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_cdb("stall.frozen", 1'b0, 4'd7, 32'h37);
    end
    rdy_in = 1'b1;
    rob_cdb_rst_in = 1'b0;
    idle();
    step();
    check_cdb("stall.resume", 1'b1, 4'd4, 32'h44);
    rdy_in = 1'b0;
    step();
    check_cdb("stall.hold_en", 1'b1, 4'd4, 32'h44);
    rdy_in = 1'b1;
    step();
    check_cdb("stall.done", 1'b0, 4'd4, 32'h44);
    step();
    check_cdb("stall.no_lsu", 1'b0, 4'd4, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
